// File: rtl/r_resp_router.sv
// AXI R-channel return router for a 2-master/2-slave interconnect.
// Each master port owns a round-robin arbiter that holds its grant for a whole burst.

module r_resp_arb (
  input  logic       gclk,
  input  logic       grst_n,
  input  logic       en_i,
  input  logic [1:0] req_i,
  input  logic [1:0] vld_i,
  input  logic [1:0] last_i,
  input  logic       rready_i,
  output logic       gnt_o,
  output logic       sel_o,
  output logic [1:0] busy_o
);
  typedef enum logic [1:0] {IDLE, BUSY_S0, BUSY_S1} st_e;

  st_e  st_q, st_d;
  logic pri_q, pri_d;
  logic gnt, hs;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      st_q  <= IDLE;
      pri_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      pri_q <= pri_d;
    end
  end

  always_comb begin
    gnt   = 1'b0;
    sel_o = 1'b0;
    st_d  = st_q;
    pri_d = pri_q;
    case (st_q)
      IDLE: begin
        if (req_i == 2'b11) begin
          gnt   = 1'b1;
          sel_o = pri_q;
        end else if (req_i[0]) begin
          gnt   = 1'b1;
          sel_o = 1'b0;
        end else if (req_i[1]) begin
          gnt   = 1'b1;
          sel_o = 1'b1;
        end
      end
      BUSY_S0: begin
        gnt   = 1'b1;
        sel_o = 1'b0;
      end
      BUSY_S1: begin
        gnt   = 1'b1;
        sel_o = 1'b1;
      end
      default: st_d = IDLE;
    endcase
    gnt_o = gnt & en_i;
    hs    = gnt_o & vld_i[sel_o] & rready_i;
    if (hs) begin
      if (last_i[sel_o]) begin
        st_d  = IDLE;
        pri_d = ~sel_o;
      end else begin
        st_d  = sel_o ? BUSY_S1 : BUSY_S0;
      end
    end
  end

  assign busy_o = {st_q == BUSY_S1, st_q == BUSY_S0};
endmodule

module r_resp_router #(
  parameter int ID_BITS   = 4,
  parameter int IDS_BITS  = 8,
  parameter int DATA_BITS = 32
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  input  logic [IDS_BITS-1:0]  RID_S0,
  input  logic [DATA_BITS-1:0] RDATA_S0,
  input  logic [1:0]           RRESP_S0,
  input  logic                 RLAST_S0,
  input  logic                 RVALID_S0,
  output logic                 RREADY_S0,
  input  logic [IDS_BITS-1:0]  RID_S1,
  input  logic [DATA_BITS-1:0] RDATA_S1,
  input  logic [1:0]           RRESP_S1,
  input  logic                 RLAST_S1,
  input  logic                 RVALID_S1,
  output logic                 RREADY_S1,
  output logic [ID_BITS-1:0]   RID_M0,
  output logic [DATA_BITS-1:0] RDATA_M0,
  output logic [1:0]           RRESP_M0,
  output logic                 RLAST_M0,
  output logic                 RVALID_M0,
  input  logic                 RREADY_M0,
  output logic [ID_BITS-1:0]   RID_M1,
  output logic [DATA_BITS-1:0] RDATA_M1,
  output logic [1:0]           RRESP_M1,
  output logic                 RLAST_M1,
  output logic                 RVALID_M1,
  input  logic                 RREADY_M1,
  output logic                 DROP_ERR
);
  localparam int MI_W = IDS_BITS - ID_BITS;

  logic [1:0][IDS_BITS-1:0]  rid_s;
  logic [1:0][DATA_BITS-1:0] dat_s;
  logic [1:0][1:0]           rsp_s;
  logic [1:0]                last_s, vld_s, rdy_s, rdy_m, lock, drop;
  logic [1:0][1:0]           req, busy;
  logic [1:0]                gnt, sel;
  logic [1:0][ID_BITS-1:0]   id_m;
  logic [1:0][DATA_BITS-1:0] dat_m;
  logic [1:0][1:0]           rsp_m;
  logic [1:0]                last_m, vld_m;
  logic                      active_q, drop_q;

  assign rid_s  = {RID_S1, RID_S0};
  assign dat_s  = {RDATA_S1, RDATA_S0};
  assign rsp_s  = {RRESP_S1, RRESP_S0};
  assign last_s = {RLAST_S1, RLAST_S0};
  assign vld_s  = {RVALID_S1, RVALID_S0};
  assign rdy_m  = {RREADY_M1, RREADY_M0};

  // Outputs stay quiet in reset and come alive on the first edge after release.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      active_q <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      active_q <= 1'b1;
      drop_q   <= |drop;
    end
  end

  // A slave locked in a burst ignores its current RID until RLAST.
  for (genvar s = 0; s < 2; s++) begin : g_slv
    logic [MI_W-1:0] idx;
    assign idx     = rid_s[s][IDS_BITS-1:ID_BITS];
    assign lock[s] = busy[0][s] | busy[1][s];
    assign drop[s] = active_q & vld_s[s] & ~lock[s] & (idx > MI_W'(1));
    for (genvar m = 0; m < 2; m++) begin : g_req
      assign req[m][s] = vld_s[s] & ~lock[s] & (idx == MI_W'(m));
    end
  end

  for (genvar m = 0; m < 2; m++) begin : g_mst
    r_resp_arb u_arb (
      .gclk     (ACLK),
      .grst_n   (ARESETn),
      .en_i     (active_q),
      .req_i    (req[m]),
      .vld_i    (vld_s),
      .last_i   (last_s),
      .rready_i (rdy_m[m]),
      .gnt_o    (gnt[m]),
      .sel_o    (sel[m]),
      .busy_o   (busy[m])
    );
    assign vld_m[m]  = gnt[m] & vld_s[sel[m]];
    assign id_m[m]   = gnt[m] ? rid_s[sel[m]][ID_BITS-1:0] : '0;
    assign dat_m[m]  = gnt[m] ? dat_s[sel[m]] : '0;
    assign rsp_m[m]  = gnt[m] ? rsp_s[sel[m]] : '0;
    assign last_m[m] = gnt[m] & last_s[sel[m]];
  end

  always_comb begin
    rdy_s = drop;
    for (int m = 0; m < 2; m++)
      for (int s = 0; s < 2; s++)
        if (gnt[m] && sel[m] == 1'(s) && rdy_m[m]) rdy_s[s] = 1'b1;
  end

  assign RREADY_S0 = rdy_s[0];
  assign RREADY_S1 = rdy_s[1];
  assign RID_M0    = id_m[0];
  assign RDATA_M0  = dat_m[0];
  assign RRESP_M0  = rsp_m[0];
  assign RLAST_M0  = last_m[0];
  assign RVALID_M0 = vld_m[0];
  assign RID_M1    = id_m[1];
  assign RDATA_M1  = dat_m[1];
  assign RRESP_M1  = rsp_m[1];
  assign RLAST_M1  = last_m[1];
  assign RVALID_M1 = vld_m[1];
  assign DROP_ERR  = drop_q;
endmodule
